// File: rtl/alu_64.sv
// 64-bit execute-stage ALU: ripple-carry add/sub, bitwise ops, NZVC flags
// plus a registered flag copy for later flag-setting instructions.
module alu_64 (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [2:0]  cntrl,
  output logic [63:0] result,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out,
  output logic [3:0]  flags_q
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  logic        is_add;
  logic        is_sub;
  logic [63:0] b_eff;
  logic [63:0] sum;
  logic        cy;
  logic        c63;
  logic        c64;
  logic [3:0]  flags_d;

  assign is_add = (cntrl == OP_ADD);
  assign is_sub = (cntrl == OP_SUB);

  // Subtract is A + ~B + 1; carries ripple slice by slice.
  always_comb begin
    b_eff = is_sub ? ~B : B;
    cy    = is_sub;
    sum   = '0;
    c63   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) c63 = cy;
      sum[i] = A[i] ^ b_eff[i] ^ cy;
      cy     = (A[i] & b_eff[i]) | (cy & (A[i] ^ b_eff[i]));
    end
    c64 = cy;
  end

  always_comb begin
    result = '0;
    case (cntrl)
      OP_PASS: result = B;
      OP_ADD:  result = sum;
      OP_SUB:  result = sum;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      default: result = '0;
    endcase
  end

  assign negative  = result[63];
  assign zero      = ~|result;
  assign overflow  = (is_add | is_sub) & (c63 ^ c64);
  // Borrow is the inverted raw carry on subtract.
  assign carry_out = is_add ? c64 : (is_sub ? ~c64 : 1'b0);

  assign flags_d = {negative, zero, overflow, carry_out};

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: tb/tb_alu_64.sv
// Scoreboard bench for alu_64: random and boundary vectors against
// a plain-arithmetic reference model, including the registered flags.
module tb_alu_64;

  logic        clk;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic [3:0]  flags_q;

  alu_64 dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .cntrl(cntrl),
    .result(result), .negative(negative), .zero(zero),
    .overflow(overflow), .carry_out(carry_out), .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
    logic [3:0]  fq;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  logic [3:0] prev_flags = 4'b0000;
  logic       prev_reset = 1'b1;

  function automatic exp_t model(logic [63:0] a, logic [63:0] b,
                                 logic [2:0] op);
    exp_t e;
    logic [64:0] w;
    e.res = '0; e.v = 1'b0; e.c = 1'b0; e.fq = '0; e.name = "";
    case (op)
      3'b000: e.res = b;
      3'b010: begin
        w = {1'b0, a} + {1'b0, b};
        e.res = w[63:0];
        e.c = w[64];
        e.v = (a[63] == b[63]) && (e.res[63] != a[63]);
      end
      3'b011: begin
        e.res = a - b;
        e.c = (a < b);
        e.v = (a[63] != b[63]) && (e.res[63] != a[63]);
      end
      3'b100: e.res = a & b;
      3'b101: e.res = a | b;
      3'b110: e.res = a ^ b;
      default: e.res = '0;
    endcase
    e.n = e.res[63];
    e.z = (e.res == 64'd0);
    return e;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] op, input logic rst,
                       input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    A = a; B = b; cntrl = op; reset = rst;
    e = model(a, b, op);
    e.name = nm;
    e.fq = prev_reset ? 4'b0000 : prev_flags;
    q.push_back(e);
    prev_flags = {e.n, e.z, e.v, e.c};
    prev_reset = rst;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(string nm, string fld, logic [63:0] act,
                     logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: combinational outputs and flags_q sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "result", result, e.res);
      chk(e.name, "negative", {63'd0, negative}, {63'd0, e.n});
      chk(e.name, "zero", {63'd0, zero}, {63'd0, e.z});
      chk(e.name, "overflow", {63'd0, overflow}, {63'd0, e.v});
      chk(e.name, "carry_out", {63'd0, carry_out}, {63'd0, e.c});
      chk(e.name, "flags_q", {60'd0, flags_q}, {60'd0, e.fq});
    end
  end

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] a;
    logic [2:0]  op;
    reset = 1'b1; A = '0; B = '0; cntrl = 3'b000;
    issue(64'd5, 64'd9, 3'b010, 1'b1, "reset");
    issue(64'd0, 64'd0, 3'b000, 1'b0, "pass_zero");
    for (int i = 0; i < 50; i++) issue(r64(), r64(), 3'b000, 1'b0, "pass_b");
    issue(64'd1, 64'd1, 3'b010, 1'b0, "add_1p1");
    issue(SMAX, 64'd1, 3'b010, 1'b0, "add_smax");
    issue(ONES, 64'd1, 3'b010, 1'b0, "add_wrap");
    issue(64'd1, 64'd1, 3'b011, 1'b0, "sub_1m1");
    issue(64'd0, 64'd1, 3'b011, 1'b0, "sub_0m1");
    issue(64'h8000_0000_0000_0000, 64'd1, 3'b011, 1'b0, "sub_smin");
    for (int i = 0; i < 50; i++) issue(r64(), r64(), 3'b011, 1'b0, "sub_rand");
    for (int i = 0; i < 50; i++) issue(r64(), r64(), 3'b010, 1'b0, "add_rand");
    for (int k = 0; k < 3; k++) begin
      op = 3'b100 + 3'(k);
      for (int i = 0; i < 25; i++) issue(r64(), r64(), op, 1'b0, "logic_rand");
      a = r64();
      issue(a, a, op, 1'b0, "logic_same");
    end
    issue(r64(), r64(), 3'b111, 1'b0, "op_111");
    issue(r64(), r64(), 3'b001, 1'b0, "op_001");
    // Reset for one edge, then wrap-add, then observe 0101 in flags_q.
    issue(SMAX, 64'd1, 3'b010, 1'b1, "fq_reset");
    issue(ONES, 64'd1, 3'b010, 1'b0, "fq_add");
    issue(r64(), r64(), 3'b111, 1'b0, "fq_0101");
    for (int i = 0; i < 120; i++)
      issue(r64(), ($urandom_range(0, 7) == 0) ? 64'd0 : r64(),
            3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
            "mixed");
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_64.md
# alu_64

64-bit combinational arithmetic/logic unit for the datapath's execute stage. Selects one of six operations on operands `A` and `B` via a 3-bit control code. Produces a 64-bit result plus negative, zero, overflow and carry/borrow flags. A registered copy of the flags is kept for later flag-setting instructions.

## Interface
- No parameters; width fixed at 64.
- `clk`  in  1  clock; used only by the flag register.
- `reset`  in  1  synchronous, active-high; clears the flag register.
- `A`  in  64  operand A.
- `B`  in  64  operand B.
- `cntrl`  in  3  operation select.
- `result`  out  64  operation result, combinational.
- `negative`  out  1  `result[63]`, combinational.
- `zero`  out  1  `result == 0`, combinational.
- `overflow`  out  1  signed overflow on add/subtract, combinational.
- `carry_out`  out  1  carry (add) or borrow (subtract), combinational.
- `flags_q`  out  4  registered `{negative, zero, overflow, carry_out}`.

## Operation
- Control codes:
  - `000` PASS_B: result = B.
  - `010` ADD: result = A + B.
  - `011` SUB: result = A − B.
  - `100` AND: result = A & B.
  - `101` OR: result = A | B.
  - `110` XOR: result = A ^ B.
  - `001` and `111`: result = 0.
- Adder structure:
  - 64 one-bit slices with ripple carry.
  - SUB is implemented as A + ~B with carry-in 1; ADD uses carry-in 0.
  - Sum wraps modulo 2^64.
- `negative` = result[63] and `zero` = NOR of all result bits; both valid for every code, including undefined codes.
- `overflow`:
  - ADD/SUB: carry into bit 63 XOR carry out of bit 63, i.e. the signed result is not representable.
  - All other codes: 0.
- `carry_out`:
  - ADD: raw carry out of bit 63, i.e. 1 when the unsigned sum ≥ 2^64.
  - SUB: borrow = inverted raw carry out of bit 63, i.e. 1 when A < B unsigned; A == B gives 0.
  - All other codes: 0.
- `flags_q`:
  - On each rising `clk`, loads the current combinational flags.
  - When `reset` = 1 at the edge, loads 4'b0000.
  - `reset` has no effect on the combinational outputs.

## Timing
- `result`, `negative`, `zero`, `overflow` and `carry_out` are purely combinational with zero cycles of latency. They settle within one propagation delay of any change on `A`, `B` or `cntrl`; no clock is needed.
- Worst-case path is the 64-bit ripple carry. It must settle well within the 100 ns stimulus interval the bench uses.
- `flags_q` has one-cycle latency: it reflects the flags present at the previous rising edge.
- Reset value: `flags_q` = 0. No other state exists.
- Mid-operation reset (reset asserted while operands change) affects `flags_q` only.

## Test plan
- PASS_B, 50 random A/B → result == B, negative == B[63], zero == (B == 0).
- ADD 1+1 → result 2, carry_out 0, overflow 0, negative 0, zero 0.
- ADD boundaries:
  - 0x7FFF_FFFF_FFFF_FFFF + 1 → result 0x8000_0000_0000_0000, overflow 1, negative 1, carry 0.
  - 0xFFFF_FFFF_FFFF_FFFF + 1 → result 0, carry_out 1, zero 1, overflow 0.
- SUB:
  - 50 random A/B → result == A−B (mod 2^64).
  - 1−1 → result 0, zero 1, carry_out 0, overflow 0, negative 0.
  - 0−1 → all-ones result, negative 1, carry_out 1.
- AND/OR/XOR, 25 random pairs each, plus B == A → result matches the bitwise operation (A&A == A, A^A == 0 with zero 1); overflow and carry_out both 0.
- flags_q:
  - reset high for one edge → flags_q == 0.
  - Then ADD 0xFFFF_FFFF_FFFF_FFFF + 1 and clock once → flags_q == 4'b0101.
  - cntrl `111` → result 0, zero 1.
